// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and defaults for the systolic array edge feeder.
//   state_e     - feeder sequencing states (IDLE, STREAM, FLUSH)
//   DEF_*       - default geometry (operand width, lane count, reduction depth)
//   lane_slice  - extract lane i from a default-geometry packed vector
package systolic_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ARRAY_SIZE = 4;
  localparam int unsigned DEF_K_DEPTH    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  function automatic logic [DEF_DATA_WIDTH-1:0] lane_slice(
    input logic [DEF_ARRAY_SIZE*DEF_DATA_WIDTH-1:0] vec,
    input int unsigned                              i
  );
    return vec[i*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/feeder_tile_buf.sv
// feeder_tile_buf: K_DEPTH x (ARRAY_SIZE*DATA_WIDTH) tile register file.
//   clk      - clock, rising edge
//   wr_en    - write strobe for wr_idx
//   wr_idx   - vector slot to write
//   wr_data  - full vector (all lanes)
//   rd_idx   - per-lane slot index, lane i at [i*IDX_W +: IDX_W]
//   rd_data  - per-lane read data, lane i taken from slot rd_idx[i], lane i
// Contents are not reset; the feeder never reads a slot it has not written.
module feeder_tile_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned K_DEPTH    = 4,
  parameter int unsigned IDX_W      = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data,
  input  logic [ARRAY_SIZE*IDX_W-1:0]      rd_idx,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] rd_data
);

  logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_q [K_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
        mem_q[rd_idx[i*IDX_W +: IDX_W]][i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: buffers one tile of operand vectors and replays it
// into the array edge with diagonal skew (lane i delayed i cycles), plus a
// staggered flush strobe sequence.
//   clk, rst  - clock (rising) / asynchronous active-high reset
//   s_valid, s_ready, s_data - upstream vector handshake (IDLE only)
//   start     - begin tile stream when buffer is full (level-sampled)
//   flush     - begin flush strobe sequence (level-sampled, start wins)
//   busy      - high while STREAM/FLUSH outputs are driven
//   done      - one-cycle pulse after a stream or flush completes
//   o_data    - skewed lane data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_finish  - per-lane finish strobe
module systolic_edge_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int unsigned K_DEPTH    = DEF_K_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] s_data,
  input  logic                             start,
  input  logic                             flush,
  output logic                             busy,
  output logic                             done,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_data,
  output logic [ARRAY_SIZE-1:0]            o_finish
);

  localparam int unsigned PTR_W  = $clog2(K_DEPTH + 1);
  localparam int unsigned T_W    = $clog2(K_DEPTH + ARRAY_SIZE);
  localparam int unsigned IDX_W  = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int unsigned VEC_W  = ARRAY_SIZE * DATA_WIDTH;
  localparam int unsigned T_LAST = K_DEPTH + ARRAY_SIZE - 2;
  localparam int unsigned F_LAST = ARRAY_SIZE - 1;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [T_W-1:0]         t_q, t_d;
  logic [VEC_W-1:0]       o_data_q, o_data_d;
  logic [ARRAY_SIZE-1:0]  o_finish_q, o_finish_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   wr_en;
  logic [T_W-1:0]         t_nxt;
  logic [ARRAY_SIZE-1:0]  lane_ok;
  logic [ARRAY_SIZE*IDX_W-1:0] rd_idx;
  logic [VEC_W-1:0]       rd_data;
  logic                   emit_stream, emit_flush;

  assign s_ready = (state_q == IDLE) && (wr_ptr_q < PTR_W'(K_DEPTH));
  assign wr_en   = s_valid && s_ready;

  feeder_tile_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_SIZE (ARRAY_SIZE),
    .K_DEPTH    (K_DEPTH),
    .IDX_W      (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_ptr_q[IDX_W-1:0]),
    .wr_data (s_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // t_q holds the step currently on the outputs; t_nxt is the step being
  // registered this cycle, so the buffer is read one step ahead.
  always_comb begin
    t_nxt   = (state_q == IDLE) ? '0 : t_q + T_W'(1);
    lane_ok = '0;
    rd_idx  = '0;
    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
      if ((32'(t_nxt) >= i) && ((32'(t_nxt) - i) < K_DEPTH)) begin
        lane_ok[i] = 1'b1;
        rd_idx[i*IDX_W +: IDX_W] = IDX_W'(32'(t_nxt) - i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    t_d         = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    o_data_d    = '0;
    o_finish_d  = '0;
    emit_stream = 1'b0;
    emit_flush  = 1'b0;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start && (wr_ptr_q == PTR_W'(K_DEPTH))) begin
          state_d     = STREAM;
          emit_stream = 1'b1;
        end else if (flush) begin
          state_d    = FLUSH;
          emit_flush = 1'b1;
        end
      end
      STREAM: begin
        if (t_q == T_W'(T_LAST)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          wr_ptr_d = '0;
        end else begin
          emit_stream = 1'b1;
        end
      end
      FLUSH: begin
        if (t_q == T_W'(F_LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          emit_flush = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit_stream || emit_flush) begin
      busy_d = 1'b1;
      t_d    = t_nxt;
    end

    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
      if (emit_stream && lane_ok[i]) begin
        o_data_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        o_finish_d[i] = (32'(t_nxt) == i);
      end
      if (emit_flush) o_finish_d[i] = (32'(t_nxt) == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      t_q        <= '0;
      o_data_q   <= '0;
      o_finish_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      t_q        <= t_d;
      o_data_q   <= o_data_d;
      o_finish_q <= o_finish_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_data   = o_data_q;
  assign o_finish = o_finish_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// tb_systolic_edge_feeder: scoreboard bench for systolic_edge_feeder.
// The stimulus process keeps a model tile (queue of accepted vectors) and,
// when it issues start/flush, pushes the expected output cycles; a monitor
// pops one entry whenever the DUT presents busy or done.
module tb_systolic_edge_feeder;
  import systolic_pkg::*;

  localparam int unsigned DW = DEF_DATA_WIDTH;
  localparam int unsigned AS = DEF_ARRAY_SIZE;
  localparam int unsigned KD = DEF_K_DEPTH;

  typedef struct {
    logic [AS*DW-1:0] data;
    logic [AS-1:0]    fin;
    logic             busy;
    logic             done;
  } exp_t;

  logic             clk, rst, s_valid, s_ready, start, flush, busy, done;
  logic [AS*DW-1:0] s_data, o_data;
  logic [AS-1:0]    o_finish;

  exp_t             exp_q[$];
  logic [AS*DW-1:0] mdl_buf[$];
  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;

  systolic_edge_feeder #(
    .DATA_WIDTH (DW),
    .ARRAY_SIZE (AS),
    .K_DEPTH    (KD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .start    (start),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .o_data   (o_data),
    .o_finish (o_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Vector k, lane i = 0x(k+1)(i+1)
  function automatic logic [AS*DW-1:0] plan_vec(input int unsigned k);
    logic [AS*DW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < AS; i++) v[i*DW +: DW] = DW'(((k + 1) << 4) | (i + 1));
    return v;
  endfunction

  // Stream: output step c, lane i shows vector c-i when that vector exists.
  task automatic push_stream();
    exp_t e;
    logic [AS*DW-1:0] v;
    for (int unsigned c = 0; c < KD + AS - 1; c++) begin
      e.data = '0; e.fin = '0; e.busy = 1'b1; e.done = 1'b0;
      for (int unsigned i = 0; i < AS; i++) begin
        if (c >= i && c - i < KD) begin
          v = mdl_buf[c - i];
          e.data[i*DW +: DW] = lane_slice(v, i);
          e.fin[i] = (c == i);
        end
      end
      exp_q.push_back(e);
    end
    e.data = '0; e.fin = '0; e.busy = 1'b0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_flush();
    exp_t e;
    for (int unsigned f = 0; f < AS; f++) begin
      e.data = '0; e.fin = AS'(1) << f; e.busy = 1'b1; e.done = 1'b0;
      exp_q.push_back(e);
    end
    e.data = '0; e.fin = '0; e.busy = 1'b0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: pops on every presented output, otherwise outputs must be idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 64'({busy, done}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("o_data",   64'(o_data),   64'(e.data));
          chk("o_finish", 64'(o_finish), 64'(e.fin));
          chk("busy",     64'(busy),     64'(e.busy));
          chk("done",     64'(done),     64'(e.done));
        end
      end else begin
        chk("idle_o_data",   64'(o_data),   64'(0));
        chk("idle_o_finish", 64'(o_finish), 64'(0));
      end
    end
  end

  task automatic load(input int unsigned cycles, input bit rand_valid, input bit plan);
    logic             v;
    logic [AS*DW-1:0] d;
    logic             exp_rdy;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      d = plan ? plan_vec(mdl_buf.size()) : AS*DW'($urandom);
      s_valid = v;
      s_data  = d;
      exp_rdy = (mdl_buf.size() < KD);
      chk("s_ready", 64'(s_ready), 64'(exp_rdy));
      if (v && exp_rdy) mdl_buf.push_back(d);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_op(input bit st, input bit fl, input bit noise);
    int unsigned n;
    bit          is_stream;
    n = 0;
    is_stream = 1'b0;
    @(negedge clk);
    start = st; flush = fl; s_valid = 1'b0;
    if (st && mdl_buf.size() == KD) begin
      push_stream();
      mdl_buf.delete();
      n = KD + AS;
      is_stream = 1'b1;
    end else if (fl) begin
      push_flush();
      n = AS + 1;
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    for (int unsigned c = 0; c < n + 2; c++) begin
      if (noise && is_stream && c == 2) begin
        start = 1'b1; flush = 1'b1; s_valid = 1'b1; s_data = AS*DW'($urandom);
        chk("s_ready_in_stream", 64'(s_ready), 64'(0));
      end else if (noise && is_stream && c == 3) begin
        start = 1'b0; flush = 1'b0; s_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned op;
    rst = 1'b1; start = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    #3;
    chk("rst_o_data",   64'(o_data),   64'(0));
    chk("rst_o_finish", 64'(o_finish), 64'(0));
    chk("rst_busy",     64'(busy),     64'(0));
    chk("rst_done",     64'(done),     64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed tile, then backpressure and start+flush together.
    load(4, 1'b0, 1'b1);
    do_op(1'b1, 1'b0, 1'b0);
    load(6, 1'b0, 1'b1);
    do_op(1'b1, 1'b1, 1'b0);

    // Partial tile: start ignored, flush keeps the partial load.
    load(3, 1'b0, 1'b1);
    do_op(1'b1, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 1'b0);
    load(2, 1'b0, 1'b1);
    do_op(1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a stream.
    load(4, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    push_stream();
    mdl_buf.delete();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_o_data",   64'(o_data),   64'(0));
    chk("midrst_o_finish", 64'(o_finish), 64'(0));
    chk("midrst_busy",     64'(busy),     64'(0));
    chk("midrst_done",     64'(done),     64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", 64'(s_ready), 64'(1));
    do_op(1'b1, 1'b0, 1'b0);

    // Randomized rounds.
    for (int unsigned r = 0; r < 12; r++) begin
      load($urandom_range(0, 8), 1'b1, 1'b0);
      op = $urandom_range(0, 3);
      do_op(op[0], op[1], op[0] && ($urandom_range(0, 1) == 1));
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_edge_feeder.md
Name: systolic_edge_feeder

Overview:
- Edge-injection front end for the output-stationary systolic array of multiply-accumulate PEs.
- Buffers one tile of operand vectors (K_DEPTH vectors of ARRAY_SIZE lanes) from an upstream valid/ready source.
- Replays the tile into the array edge with diagonal skew: lane i delayed i cycles. Drives the per-lane finish strobe each PE uses to latch its sum and restart accumulation.
- One instance per array edge (left and top). Both are started by the same controller.

Parameters:
- DATA_WIDTH, 8, operand width per lane
- ARRAY_SIZE, 4, lane count (array rows or columns)
- K_DEPTH, 4, vectors per tile (reduction length)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  upstream vector valid
- s_ready  out  1  feeder can accept a vector
- s_data  in  ARRAY_SIZE*DATA_WIDTH  vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- start  in  1  request tile stream (level-sampled)
- flush  in  1  request flush sequence (level-sampled)
- busy  out  1  high in STREAM or FLUSH
- done  out  1  one-cycle completion pulse
- o_data  out  ARRAY_SIZE*DATA_WIDTH  skewed lane data to array edge
- o_finish  out  ARRAY_SIZE  per-lane finish strobe to the lane's first PE

Behaviour:
- Reset (async, active-high): state=IDLE, wr_ptr=0, t=0, o_data=0, o_finish=0, done=0, busy=0. Buffer contents are don't-care. s_ready=1 once rst is low.
- States are IDLE, STREAM and FLUSH.
- Load (IDLE only):
  - s_ready = (state==IDLE) && (wr_ptr<K_DEPTH). This is combinational from registers only.
  - On s_valid&&s_ready, write s_data to buf[wr_ptr] and increment wr_ptr.
  - Vectors offered while full or not in IDLE are not accepted; upstream holds them.
- IDLE→STREAM: start sampled high while wr_ptr==K_DEPTH. A start when not full is ignored with no error.
- IDLE→FLUSH: flush sampled high and the start condition is not met. Start wins when both are valid.
- STREAM:
  - Counter t runs 0..K_DEPTH+ARRAY_SIZE-2, one value per cycle.
  - Outputs are registered. The value for t appears on o_data/o_finish in the cycle after t is computed. The first output cycle is the cycle after start is sampled.
  - Lane i: k=t-i. If 0<=k<K_DEPTH, o_data lane i = buf[k][i]; otherwise 0.
  - o_finish[i]=1 exactly when k==0. The PE therefore latches the previous tile's sum and seeds the new sum with the first product.
  - After the last t: return to IDLE, wr_ptr=0, done=1 for one cycle. That IDLE cycle has o_data=0 and o_finish=0.
  - start, flush and s_valid are ignored while in STREAM.
- FLUSH:
  - Runs ARRAY_SIZE cycles, f=0..ARRAY_SIZE-1.
  - Output cycle f: o_finish = one-hot bit f, o_data = 0. This latches the final tile result in every PE with a staggered strobe.
  - Then return to IDLE with done=1 for one cycle. wr_ptr is unchanged.
- busy is registered and is high in exactly the cycles where STREAM/FLUSH outputs are driven.
- Widths: wr_ptr is $clog2(K_DEPTH+1) bits. t is $clog2(K_DEPTH+ARRAY_SIZE) bits. No arithmetic on data; pass-through only.
- Reset mid-operation: all outputs go to 0 immediately (async) and the tile is discarded (wr_ptr=0). Downstream PEs keep partial sums; the controller re-issues the tile.
- ARRAY_SIZE=1: stream length is K_DEPTH and flush is 1 cycle.

Decomposition:
- Shared package systolic_pkg holds:
  - state enum (IDLE, STREAM, FLUSH)
  - default DATA_WIDTH / ARRAY_SIZE / K_DEPTH constants
  - function lane_slice(vec, i)
- One sub-module, feeder_tile_buf: K_DEPTH×(ARRAY_SIZE*DATA_WIDTH) register file with one write port and ARRAY_SIZE independent combinational read ports (per-lane index).

Test Plan (DATA_WIDTH=8, ARRAY_SIZE=4, K_DEPTH=4; vector k lane i = 0x(k+1)(i+1)):
- Reset: assert rst mid-cycle → o_data=0, o_finish=0, busy=0, done=0 asynchronously; after release s_ready=1.
- Load 4 vectors, pulse start → 7 output cycles:
  - c0: lane0=0x11, finish=0001
  - c1: lane0=0x21, lane1=0x12, finish=0010
  - c3: lanes=0x41,0x32,0x23,0x14, finish=1000
  - c6: lane3=0x44, others 0, finish=0000
  - c7: done=1, busy=0, s_ready=1
- Backpressure: s_valid held 6 cycles → exactly 4 handshakes, s_ready low from the 5th cycle. Start with only 3 loaded → no busy, no output.
- Flush in IDLE → 4 cycles of o_finish 0001,0010,0100,1000 with o_data=0, then done pulse. wr_ptr is preserved (partial load continues afterwards).
- Start and flush together with a full buffer → STREAM taken. Start/flush/s_valid pulsed during STREAM → ignored; stream still 7 cycles with one done.
- Async rst at stream c3 → outputs 0 immediately; after release s_ready=1, and start without a reload yields no output.
